star_collect_ctrl: RTL and testbench

- Frame-synchronous controller that owns the collectible-star table for a level.
- Once per frame it time-multiplexes one shared bounding-box overlap unit across NUM_STARS star slots, testing each against the character position.
- Clears the enable of any star that was touched, pulses a collect event and keeps the collected-star count.
- Sits between the character/scroll logic (char_X, char_Y, bg_pos) and the render/score logic (star_en, screen X, count).

---
 rtl/star_pkg.sv | 24 ++
 rtl/star_aabb_overlap.sv | 27 ++
 rtl/star_collect_ctrl.sv | 174 +++++++++++++++++
 tb/tb_star_collect_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/star_pkg.sv
// Shared definitions for the star-collection controller: coordinate width,
// default box sizes, FSM encoding and packed-bus slot extraction.
package star_pkg;

  localparam int COORD_W       = 10;
  localparam int MAX_STARS     = 8;
  localparam int STAR_SIZE_DEF = 12;
  localparam int CHAR_SIZE_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } star_state_e;

  // Buses are zero-extended to MAX_STARS slots so one helper serves every build
  function automatic logic [COORD_W-1:0] slot_coord(
    input logic [COORD_W*MAX_STARS-1:0] bus,
    input logic [2:0]                   idx
  );
    slot_coord = bus[int'(idx)*COORD_W +: COORD_W];
  endfunction

endpackage

// File: rtl/star_aabb_overlap.sv
// Combinational bounding-box overlap test between the character and one star,
// evaluated at 11 bits so boxes near the 1023 edge never wrap.
module star_aabb_overlap
  import star_pkg::*;
#(
  parameter int STAR_SIZE = STAR_SIZE_DEF,
  parameter int CHAR_SIZE = CHAR_SIZE_DEF
) (
  input  logic [COORD_W-1:0] c_x,
  input  logic [COORD_W-1:0] c_y,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  output logic               hit
);

  // Either the near or the far edge of the character lies within the star span
  function automatic logic axis_hit(input logic [COORD_W:0] c, input logic [COORD_W:0] s);
    logic [COORD_W:0] s_far;
    logic [COORD_W:0] c_far;
    s_far = s + (COORD_W+1)'(STAR_SIZE);
    c_far = c + (COORD_W+1)'(CHAR_SIZE);
    axis_hit = ((c >= s) && (c <= s_far)) || ((c_far >= s) && (c_far <= s_far));
  endfunction

  assign hit = axis_hit({1'b0, c_x}, {1'b0, s_x}) & axis_hit({1'b0, c_y}, {1'b0, s_y});

endmodule

// File: rtl/star_collect_ctrl.sv
// Per-frame star collection: scans every slot through one shared overlap unit,
// retires touched stars, pulses a collect event and keeps the collected count.
module star_collect_ctrl
  import star_pkg::*;
#(
  parameter int NUM_STARS = 4,
  parameter int STAR_SIZE = STAR_SIZE_DEF,
  parameter int CHAR_SIZE = CHAR_SIZE_DEF,
  parameter int CNT_W     = 4
) (
  input  logic                         sys_clk,
  input  logic                         RST,
  input  logic                         frame_tick,
  input  logic                         level_restart,
  input  logic [COORD_W-1:0]           char_X,
  input  logic [COORD_W-1:0]           char_Y,
  input  logic [COORD_W-1:0]           bg_pos,
  input  logic [COORD_W*NUM_STARS-1:0] star_pos_x,
  input  logic [COORD_W*NUM_STARS-1:0] star_pos_y,
  output logic [NUM_STARS-1:0]         star_en,
  output logic [COORD_W*NUM_STARS-1:0] star_scr_x,
  output logic                         collect_pulse,
  output logic [2:0]                   collect_idx,
  output logic [CNT_W-1:0]             star_count,
  output logic                         all_collected,
  output logic                         scan_busy
);

  localparam logic [2:0]       LAST_IDX = 3'(NUM_STARS-1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  star_state_e                  state_r, state_nxt_s;
  logic [2:0]                   idx_r, idx_nxt_s;
  logic [COORD_W-1:0]           snap_x_r, snap_x_nxt_s;
  logic [COORD_W-1:0]           snap_y_r, snap_y_nxt_s;
  logic [NUM_STARS-1:0]         star_en_r, star_en_nxt_s;
  logic [NUM_STARS-1:0]         slot_sel_s;
  logic                         pulse_r, pulse_nxt_s;
  logic [2:0]                   cidx_r, cidx_nxt_s;
  logic [CNT_W-1:0]             count_r, count_nxt_s;
  logic                         all_r, all_nxt_s;
  logic                         busy_r, busy_nxt_s;
  logic [COORD_W*MAX_STARS-1:0] pos_x_ext_s, pos_y_ext_s;
  logic [COORD_W-1:0]           cur_sx_s, cur_sy_s;
  logic                         overlap_s, cur_en_s, hit_s, last_slot_s;

  // Widen the packed position buses to the fixed width the slot helper expects
  always_comb begin
    pos_x_ext_s = {(COORD_W*MAX_STARS){1'b0}};
    pos_y_ext_s = {(COORD_W*MAX_STARS){1'b0}};
    pos_x_ext_s[COORD_W*NUM_STARS-1:0] = star_pos_x;
    pos_y_ext_s[COORD_W*NUM_STARS-1:0] = star_pos_y;
  end

  assign cur_sx_s = slot_coord(pos_x_ext_s, idx_r);
  assign cur_sy_s = slot_coord(pos_y_ext_s, idx_r);

  star_aabb_overlap #(
    .STAR_SIZE (STAR_SIZE),
    .CHAR_SIZE (CHAR_SIZE)
  ) u_overlap (
    .c_x (snap_x_r),
    .c_y (snap_y_r),
    .s_x (cur_sx_s),
    .s_y (cur_sy_s),
    .hit (overlap_s)
  );

  // One-hot select of the slot under test and its current enable
  always_comb begin
    slot_sel_s = {NUM_STARS{1'b0}};
    for (int i = 0; i < NUM_STARS; i++) begin
      slot_sel_s[i] = (idx_r == 3'(i));
    end
    cur_en_s = |(star_en_r & slot_sel_s);
  end

  assign hit_s       = overlap_s & cur_en_s & (state_r == SCAN);
  assign last_slot_s = (idx_r == LAST_IDX);

  // Screen position is plain modular subtraction; culling happens downstream
  for (genvar g = 0; g < NUM_STARS; g++) begin : g_scr
    assign star_scr_x[g*COORD_W +: COORD_W] = star_pos_x[g*COORD_W +: COORD_W] - bg_pos;
  end

  // Next-state, table update and event generation
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    snap_x_nxt_s  = snap_x_r;
    snap_y_nxt_s  = snap_y_r;
    star_en_nxt_s = star_en_r;
    pulse_nxt_s   = 1'b0;
    cidx_nxt_s    = cidx_r;
    count_nxt_s   = count_r;
    if (level_restart) begin
      state_nxt_s   = IDLE;
      idx_nxt_s     = 3'd0;
      star_en_nxt_s = {NUM_STARS{1'b1}};
      count_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_tick) begin
            state_nxt_s  = SCAN;
            idx_nxt_s    = 3'd0;
            snap_x_nxt_s = char_X;
            snap_y_nxt_s = char_Y;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SCAN: begin
          if (hit_s) begin
            star_en_nxt_s = star_en_r & ~slot_sel_s;
            pulse_nxt_s   = 1'b1;
            cidx_nxt_s    = idx_r;
            if (count_r != CNT_MAX) begin
              count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              count_nxt_s = count_r;
            end
          end else begin
            pulse_nxt_s = 1'b0;
          end
          if (last_slot_s) begin
            state_nxt_s = DONE;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
    all_nxt_s  = (star_en_nxt_s == {NUM_STARS{1'b0}});
    busy_nxt_s = (state_nxt_s == SCAN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (RST) begin
      state_r   <= IDLE;
      idx_r     <= 3'd0;
      snap_x_r  <= {COORD_W{1'b0}};
      snap_y_r  <= {COORD_W{1'b0}};
      star_en_r <= {NUM_STARS{1'b1}};
      pulse_r   <= 1'b0;
      cidx_r    <= 3'd0;
      count_r   <= {CNT_W{1'b0}};
      all_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      snap_x_r  <= snap_x_nxt_s;
      snap_y_r  <= snap_y_nxt_s;
      star_en_r <= star_en_nxt_s;
      pulse_r   <= pulse_nxt_s;
      cidx_r    <= cidx_nxt_s;
      count_r   <= count_nxt_s;
      all_r     <= all_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign star_en       = star_en_r;
  assign collect_pulse = pulse_r;
  assign collect_idx   = cidx_r;
  assign star_count    = count_r;
  assign all_collected = all_r;
  assign scan_busy     = busy_r;

endmodule

// File: tb/tb_star_collect_ctrl.sv
// Scoreboard bench for star_collect_ctrl: directed scenarios push expected
// collect events; a negedge monitor pops and compares each collect_pulse.
module tb_star_collect_ctrl;

  logic        sys_clk = 1'b0;
  logic        RST = 1'b1;
  logic        frame_tick = 1'b0;
  logic        level_restart = 1'b0;
  logic [9:0]  char_X = 10'd0;
  logic [9:0]  char_Y = 10'd0;
  logic [9:0]  bg_pos = 10'd0;
  logic [39:0] star_pos_x = 40'd0;
  logic [39:0] star_pos_y = 40'd0;

  logic [3:0]  star_en;
  logic [39:0] star_scr_x;
  logic        collect_pulse;
  logic [2:0]  collect_idx;
  logic [3:0]  star_count;
  logic        all_collected;
  logic        scan_busy;

  logic [3:0]  en2;
  logic [39:0] scr2;
  logic        pulse2;
  logic [2:0]  cidx2;
  logic [1:0]  cnt2;
  logic        all2;
  logic        busy2;

  star_collect_ctrl #(.NUM_STARS(4), .STAR_SIZE(12), .CHAR_SIZE(12), .CNT_W(4)) u_dut (
    .sys_clk(sys_clk), .RST(RST), .frame_tick(frame_tick), .level_restart(level_restart),
    .char_X(char_X), .char_Y(char_Y), .bg_pos(bg_pos),
    .star_pos_x(star_pos_x), .star_pos_y(star_pos_y),
    .star_en(star_en), .star_scr_x(star_scr_x), .collect_pulse(collect_pulse),
    .collect_idx(collect_idx), .star_count(star_count), .all_collected(all_collected),
    .scan_busy(scan_busy)
  );

  // Narrow-counter build to exercise saturation
  star_collect_ctrl #(.NUM_STARS(4), .STAR_SIZE(12), .CHAR_SIZE(12), .CNT_W(2)) u_dut_sat (
    .sys_clk(sys_clk), .RST(RST), .frame_tick(frame_tick), .level_restart(level_restart),
    .char_X(char_X), .char_Y(char_Y), .bg_pos(bg_pos),
    .star_pos_x(star_pos_x), .star_pos_y(star_pos_y),
    .star_en(en2), .star_scr_x(scr2), .collect_pulse(pulse2),
    .collect_idx(cidx2), .star_count(cnt2), .all_collected(all2),
    .scan_busy(busy2)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         idx;
    int         cnt;
    logic [3:0] en;
    logic       all;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   cyc = 0;
  int   busy_total = 0;
  int   t_tick = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) busy_total <= busy_total + int'(scan_busy);

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: every collect_pulse must match the head of the scoreboard
  always @(negedge sys_clk) begin
    if (!RST && collect_pulse) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(collect_pulse), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("collect_idx", int'(collect_idx), e.idx);
        chk("count_at_pulse", int'(star_count), e.cnt);
        chk("en_at_pulse", int'(star_en), int'(e.en));
        chk("all_at_pulse", int'(all_collected), int'(e.all));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_slot(input int k, input int x, input int y);
    star_pos_x[k*10 +: 10] = 10'(x);
    star_pos_y[k*10 +: 10] = 10'(y);
  endtask

  task automatic pulse_tick();
    @(posedge sys_clk); #1;
    frame_tick = 1'b1;
    t_tick = cyc;
    @(posedge sys_clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    @(posedge sys_clk); #1;
    level_restart = 1'b1;
    @(posedge sys_clk); #1;
    level_restart = 1'b0;
  endtask

  task automatic push_exp(input int k, input int cnt, input logic [3:0] en, input logic all);
    exp_t e;
    e.idx = k; e.cnt = cnt; e.en = en; e.all = all; e.cyc = t_tick + k + 2;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    int b0;
    logic [3:0] m;
    logic [3:0] full;
    for (int k = 0; k < 4; k++) set_slot(k, 900, 500);
    repeat (2) @(posedge sys_clk);
    #1 RST = 1'b0;
    @(negedge sys_clk);
    chk("rst_en", int'(star_en), 15);
    chk("rst_pulse", int'(collect_pulse), 0);
    chk("rst_idx", int'(collect_idx), 0);
    chk("rst_count", int'(star_count), 0);
    chk("rst_all", int'(all_collected), 0);
    chk("rst_busy", int'(scan_busy), 0);

    // Single hit on slot 0 plus busy window T+1..T+4
    set_slot(0, 347, 56);
    char_X = 10'd340; char_Y = 10'd50;
    pulse_tick();
    push_exp(0, 1, 4'b1110, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      chk($sformatf("busy_T+%0d", k), int'(scan_busy), (k <= 4) ? 1 : 0);
    end
    wait_neg(2);
    chk("single_en", int'(star_en), 14);
    chk("single_count", int'(star_count), 1);
    chk("single_cnt_sat_build", int'(cnt2), 1);

    // No re-fire on a collected slot
    pulse_tick();
    wait_neg(8);
    chk("refire_count", int'(star_count), 1);
    chk("refire_en", int'(star_en), 14);

    // Far-edge boundary: exact touch hits, one pixel short misses
    pulse_restart();
    @(negedge sys_clk);
    chk("restart_en", int'(star_en), 15);
    chk("restart_count", int'(star_count), 0);
    char_X = 10'd335; char_Y = 10'd44;
    pulse_tick();
    push_exp(0, 1, 4'b1110, 1'b0);
    wait_neg(8);
    chk("edge_hit_count", int'(star_count), 1);
    pulse_restart();
    char_X = 10'd334;
    pulse_tick();
    wait_neg(8);
    chk("edge_miss_count", int'(star_count), 0);
    chk("edge_miss_en", int'(star_en), 15);

    // Tick during SCAN is dropped: exactly one scan's worth of busy cycles
    b0 = busy_total;
    @(posedge sys_clk); #1 frame_tick = 1'b1;
    @(posedge sys_clk); #1 frame_tick = 1'b1;
    @(posedge sys_clk); #1 frame_tick = 1'b0;
    wait_neg(10);
    chk("midscan_tick_busy", busy_total - b0, 4);

    // Restart at T+2 while slot 1 is under test aborts the scan
    set_slot(0, 900, 500);
    set_slot(1, 347, 56);
    char_X = 10'd340; char_Y = 10'd50;
    @(posedge sys_clk); #1 frame_tick = 1'b1;
    @(posedge sys_clk); #1 frame_tick = 1'b0;
    @(posedge sys_clk); #1 level_restart = 1'b1;
    @(posedge sys_clk); #1 level_restart = 1'b0;
    @(negedge sys_clk);
    chk("abort_busy_T+3", int'(scan_busy), 0);
    chk("abort_en", int'(star_en), 15);
    chk("abort_count", int'(star_count), 0);
    wait_neg(6);

    // Wrap safety: no hit across the 1023/0 boundary
    set_slot(1, 900, 500);
    set_slot(0, 1015, 56);
    char_X = 10'd5; char_Y = 10'd56;
    pulse_tick();
    wait_neg(8);
    chk("wrap_count", int'(star_count), 0);

    // Screen X is modular subtraction
    set_slot(0, 347, 56);
    set_slot(2, 0, 500);
    bg_pos = 10'd400;
    #1;
    chk("scr_x_slot0", int'(star_scr_x[9:0]), 971);
    chk("scr_x_slot1", int'(star_scr_x[19:10]), 500);
    chk("scr_x_slot2", int'(star_scr_x[29:20]), 624);
    bg_pos = 10'd0;

    // Collect all four in one frame; narrow build saturates at 3
    for (int k = 0; k < 4; k++) set_slot(k, 347, 56);
    char_X = 10'd340; char_Y = 10'd50;
    pulse_tick();
    full = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      m = full << (k + 1);
      push_exp(k, k + 1, m, (k == 3) ? 1'b1 : 1'b0);
    end
    wait_neg(8);
    chk("all_count", int'(star_count), 4);
    chk("all_en", int'(star_en), 0);
    chk("all_flag", int'(all_collected), 1);
    chk("sat_count", int'(cnt2), 3);
    chk("sat_all_flag", int'(all2), 1);
    pulse_tick();
    wait_neg(8);
    chk("all_rescan_count", int'(star_count), 4);
    pulse_restart();
    @(negedge sys_clk);
    chk("restart_all_flag", int'(all_collected), 0);
    chk("restart_count2", int'(star_count), 0);
    chk("restart_sat_count", int'(cnt2), 0);

    wait_neg(2);
    chk("missing_pulse", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
